// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - sequential instruction fetch with credit-limited imem requests and in-order FIFO
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic          req_valid_q, req_valid_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   deliver_pc_q, deliver_pc_d;
  logic [3:0]    inflight_q, inflight_d;
  logic [3:0]    drop_q, drop_d;
  logic          orphan_q, orphan_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [64:0]   ent_q [DEPTH];

  logic        req_fire, rsp_acc, push, pop, can_raise;
  logic [31:0] occ;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  always_comb begin
    req_fire     = req_valid_q & req_ready;
    rsp_acc      = rsp_valid & (inflight_q != '0);
    pop          = (count_q != '0) & inst_ready;
    push         = rsp_acc & (drop_q == '0) & ~redirect_valid;
    inflight_d   = inflight_q + 4'(req_fire) - 4'(rsp_acc);
    req_valid_d  = req_valid_q & ~req_fire;
    req_addr_d   = req_addr_q;
    fetch_pc_d   = fetch_pc_q;
    deliver_pc_d = deliver_pc_q;
    drop_d       = drop_q;
    orphan_d     = orphan_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    occ          = '0;
    can_raise    = 1'b0;
    if (redirect_valid) begin
      // An unaccepted request is marked orphan; it joins drop only once it actually fires.
      drop_d       = inflight_d;
      orphan_d     = req_valid_q & ~req_fire;
      fetch_pc_d   = {redirect_pc[31:2], 2'b00};
      deliver_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
    end else begin
      drop_d = drop_q - 4'(rsp_acc & (drop_q != '0)) + 4'(req_fire & orphan_q);
      if (req_fire) begin
        orphan_d = 1'b0;
        if (!orphan_q) fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        deliver_pc_d = deliver_pc_q + 32'd4;
        wr_ptr_d     = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d   = count_q + CW'(push) - CW'(pop);
      occ       = 32'(count_d) + 32'(inflight_d - drop_d);
      can_raise = (32'(inflight_d) < MAX_OUT) && (occ < DEPTH);
      if (!req_valid_d && can_raise) begin
        req_valid_d = 1'b1;
        req_addr_d  = fetch_pc_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid_q  <= 1'b0;
      req_addr_q   <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      deliver_pc_q <= RESET_PC;
      inflight_q   <= '0;
      drop_q       <= '0;
      orphan_q     <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      fetch_pc_q   <= fetch_pc_d;
      deliver_pc_q <= deliver_pc_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      orphan_q     <= orphan_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Entry storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) ent_q[wr_ptr_q] <= {rsp_err, deliver_pc_q, rsp_data};
  end

  assign req_valid  = req_valid_q;
  assign req_addr   = req_addr_q;
  assign rsp_ready  = 1'b1;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? ent_q[rd_ptr_q][31:0]  : '0;
  assign inst_pc    = inst_valid ? ent_q[rd_ptr_q][63:32] : '0;
  assign inst_err   = inst_valid & ent_q[rd_ptr_q][64];

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - table, directed and random checks of ifu_fetch against an in-order stream model
module tb_ifu_fetch;

  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam int          MAXO = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0, rsp_ready;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        inst_err;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RPC), .DEPTH(4), .MAX_OUT(MAXO)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_err(inst_err)
  );

  int total = 0, bad = 0, cyc = 0;
  int pop_cnt = 0, fire_cnt = 0, rsp_cnt = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic        rr = 1'b0, ir = 1'b0, redir = 1'b0;
  logic [31:0] redir_pc = '0;
  int          lat = 1;
  bit          rand_lat = 0;
  logic [31:0] exp_pc, exp_req, prev_addr, last_pop_pc, held;
  bit          skip, prev_pend, empty_chk;

  typedef struct {
    logic        rr, ir;
    logic        ev;
    logic [31:0] ea;
    logic        iv;
    logic [31:0] ip;
    logic        ie;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic errw(input logic [31:0] a);
    return (a == 32'h8000_0008) || (a[7:2] == 6'h2b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    q_addr.delete();
    q_due.delete();
    exp_pc    = RPC;
    exp_req   = RPC;
    skip      = 0;
    prev_pend = 0;
    empty_chk = 0;
  endtask

  // Called at a negedge: drive inputs, play imem, score the upcoming edge, advance one cycle.
  task automatic step();
    req_ready      = rr;
    inst_ready     = ir;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = memw(q_addr[0]);
      rsp_err   = errw(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
      rsp_cnt++;
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
      rsp_err   = 1'b0;
    end
    if (prev_pend) begin
      chk("req_hold_valid", req_valid, 1);
      chk("req_hold_addr", req_addr, prev_addr);
    end
    if (empty_chk) chk("flush_empty", inst_valid, 0);
    if (inst_valid && ir && !redir) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", inst, memw(exp_pc));
      chk("inst_err", inst_err, errw(exp_pc));
      last_pop_pc = inst_pc;
      exp_pc += 32'd4;
      pop_cnt++;
    end
    if (req_valid && rr) begin
      if (skip) skip = 0;
      else begin
        chk("req_addr", req_addr, exp_req);
        exp_req += 32'd4;
      end
      q_addr.push_back(req_addr);
      q_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 6)) : lat));
      fire_cnt++;
    end
    chk("outstanding", q_addr.size() <= MAXO, 1);
    prev_pend = req_valid && !rr;
    prev_addr = req_addr;
    empty_chk = redir;
    if (redir) begin
      exp_pc  = {redir_pc[31:2], 2'b00};
      exp_req = exp_pc;
      skip    = req_valid && !rr;
    end
    redir = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    req_ready      = 1'b0;
    inst_ready     = 1'b0;
    rsp_valid      = 1'b0;
    redirect_valid = 1'b0;
    redir          = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, RPC);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_err", inst_err, 0);
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'h0,         1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0,         1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0,         1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_000c, 1'b1, 32'h8000_0004, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_000c, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h8000_0018, 1'b1, 32'h8000_0010, 1'b0};

    @(negedge clk);
    do_reset();
    lat = 1;
    for (int k = 0; k < 8; k++) begin
      rr = tbl[k].rr;
      ir = tbl[k].ir;
      chk("t_req_valid", req_valid, tbl[k].ev);
      chk("t_req_addr", req_addr, tbl[k].ea);
      chk("t_inst_valid", inst_valid, tbl[k].iv);
      if (tbl[k].iv) begin
        chk("t_inst_pc", inst_pc, tbl[k].ip);
        chk("t_inst_err", inst_err, tbl[k].ie);
      end
      step();
    end

    // Stalled core: exactly DEPTH entries buffered, then fetch resumes at 80000010.
    do_reset();
    rr = 1'b1; ir = 1'b0; lat = 1;
    fire_cnt = 0; rsp_cnt = 0; pop_cnt = 0;
    repeat (12) step();
    chk("s2_fires", fire_cnt, 4);
    chk("s2_rsps", rsp_cnt, 4);
    chk("s2_req_valid", req_valid, 0);
    chk("s2_inst_valid", inst_valid, 1);
    ir = 1'b1;
    repeat (4) step();
    chk("s2_pops", pop_cnt, 4);
    repeat (4) step();
    chk("s2_resume", exp_req > 32'h8000_0010, 1);

    // Redirect with three requests in flight.
    lat = 5;
    for (int n = 0; n < 50 && q_addr.size() != 3; n++) step();
    chk("s3_inflight", q_addr.size(), 3);
    redir = 1'b1; redir_pc = 32'h8000_0102;
    step();
    pop_cnt = 0;
    for (int n = 0; n < 40 && pop_cnt == 0; n++) step();
    chk("s3_popped", pop_cnt > 0, 1);
    chk("s3_first_pc", last_pop_pc, 32'h8000_0100);

    // Redirect while a request is held unaccepted.
    lat = 2; rr = 1'b0;
    for (int n = 0; n < 40 && !req_valid; n++) step();
    chk("s4_pending", req_valid, 1);
    held = req_addr;
    redir = 1'b1; redir_pc = 32'h8000_0200;
    pop_cnt = 0;
    step();
    repeat (3) step();
    chk("s4_hold", req_addr, held);
    rr = 1'b1;
    for (int n = 0; n < 40 && pop_cnt == 0; n++) step();
    chk("s4_popped", pop_cnt > 0, 1);
    chk("s4_first_pc", last_pop_pc, 32'h8000_0200);

    // Asynchronous reset between edges mid-stream.
    repeat (10) step();
    #2 rst = 1'b0;
    #1;
    chk("s6_req_valid", req_valid, 0);
    chk("s6_req_addr", req_addr, RPC);
    chk("s6_inst_valid", inst_valid, 0);
    chk("s6_inst", inst, 0);
    chk("s6_inst_pc", inst_pc, 0);
    chk("s6_inst_err", inst_err, 0);
    @(negedge clk);
    do_reset();
    pop_cnt = 0;
    repeat (10) step();
    chk("s6_restart", pop_cnt > 0, 1);

    // Random traffic with random latency, back-pressure and redirects.
    rand_lat = 1;
    pop_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redir    = 1'b1;
        redir_pc = ($urandom_range(0, 3) == 0) ? 32'hffff_fff4 : $urandom;
      end
      step();
    end
    chk("rand_progress", pop_cnt > 500, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
